ex_mem_register: RTL and testbench

//   EX/MEM pipeline stage register directly downstream of the 32-bit ALU.
//   - Captures ALUResult/Zero plus forwarded store data, destination register and MEM/WB control.
//   - Resolves conditional branches (beq/bne/bgez/bgtz/blez/bltz) from the ALU flags.
//   - Honours pipeline stall and flush, and presents registered outputs to the data-memory stage.

---
 rtl/ece369_pkg.sv | 49 ++++
 rtl/ex_mem_register_branch_resolve.sv | 32 +++
 rtl/ex_mem_register.sv | 119 +++++++++++
 tb/tb_ex_mem_register.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ece369_pkg.sv
// ece369_pkg
//   Shared definitions for the EX/MEM stage: default widths, branch-type
//   and memory-size encodings, the MEM/WB control bundle, and the alignment
//   helper used when MISALIGN_CHECK_EN is defined.
package ece369_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;

    typedef enum logic [2:0] {
        BR_NONE  = 3'd0,
        BR_BEQ   = 3'd1,
        BR_BNE   = 3'd2,
        BR_BGEZ  = 3'd3,
        BR_BGTZ  = 3'd4,
        BR_BLEZ  = 3'd5,
        BR_BLTZ  = 3'd6,
        BR_NONE7 = 3'd7
    } br_type_e;

    typedef enum logic [1:0] {
        MS_WORD = 2'b00,
        MS_HALF = 2'b01,
        MS_BYTE = 2'b10,
        MS_RSVD = 2'b11
    } mem_size_e;

    // MEM/WB control carried through the stage.
    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
    } ctrl_t;

    // Misaligned if a word (or the reserved size, treated as word) is not
    // 4-byte aligned, or a halfword is not 2-byte aligned. Bytes never fault.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic m;
        m = 1'b0;
        case (mem_size_e'(size))
            MS_WORD, MS_RSVD: m = (lsb != 2'b00);
            MS_HALF:          m = lsb[0];
            default:          m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ex_mem_register_branch_resolve.sv
// branch_resolve
//   Combinational branch decision from the ALU flags. The ALU has already
//   computed A-B (B=0 for the zero-compare forms), so only Zero and the
//   result sign bit are needed.
// Ports
//   branch_type  in  3  branch encoding (br_type_e)
//   zero         in  1  ALU Zero flag
//   sign         in  1  ALU result MSB
//   taken        out 1  compare result (not gated by valid)
module branch_resolve
    import ece369_pkg::*;
(
    input  logic [2:0] branch_type,
    input  logic       zero,
    input  logic       sign,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (br_type_e'(branch_type))
            BR_BEQ:  taken = zero;
            BR_BNE:  taken = ~zero;
            BR_BGEZ: taken = ~sign;
            BR_BGTZ: taken = ~sign & ~zero;
            BR_BLEZ: taken = sign | zero;
            BR_BLTZ: taken = sign;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_register.sv
// ex_mem_register
//   EX/MEM pipeline register downstream of the ALU. Captures the ALU result,
//   store data, destination register and MEM/WB control, and resolves
//   conditional branches. All outputs are registered (one-cycle latency).
//   Per-edge priority: Reset (sync, active low) > Flush > Stall > load.
// Ports
//   Clk, Reset, Stall, Flush        clock / sync active-low reset / hold / bubble
//   ValidIn ... BranchTargetIn      EX-stage payload
//   ValidOut ... MemSizeOut         registered payload
//   BranchTaken, BranchTarget       registered branch resolution
//   AddrErr                         misalignment flag (MISALIGN_CHECK_EN only)
// Configuration
//   MISALIGN_CHECK_EN: adds AddrErr and suppresses memory/regfile writes on
//   a misaligned valid load/store.
module ex_mem_register
    import ece369_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  ValidIn,
    input  logic [DATA_W-1:0]     ALUResultIn,
    input  logic                  ZeroIn,
    input  logic [DATA_W-1:0]     StoreDataIn,
    input  logic [REG_ADDR_W-1:0] WriteRegIn,
    input  logic                  RegWriteIn,
    input  logic                  MemReadIn,
    input  logic                  MemWriteIn,
    input  logic                  MemToRegIn,
    input  logic [1:0]            MemSizeIn,
    input  logic [2:0]            BranchTypeIn,
    input  logic [DATA_W-1:0]     BranchTargetIn,
    output logic                  ValidOut,
    output logic [DATA_W-1:0]     ALUResultOut,
    output logic [DATA_W-1:0]     StoreDataOut,
    output logic [REG_ADDR_W-1:0] WriteRegOut,
    output logic                  RegWriteOut,
    output logic                  MemReadOut,
    output logic                  MemWriteOut,
    output logic                  MemToRegOut,
    output logic [1:0]            MemSizeOut,
    output logic                  BranchTaken,
    output logic [DATA_W-1:0]     BranchTarget
`ifdef MISALIGN_CHECK_EN
    ,
    output logic                  AddrErr
`endif
);

    logic  br_cmp;
    logic  taken_nxt;
    logic  addr_err_nxt;
    ctrl_t ctrl_nxt;

    branch_resolve u_branch_resolve (
        .branch_type (BranchTypeIn),
        .zero        (ZeroIn),
        .sign        (ALUResultIn[DATA_W-1]),
        .taken       (br_cmp)
    );

    always_comb begin
        addr_err_nxt = 1'b0;
`ifdef MISALIGN_CHECK_EN
        addr_err_nxt = ValidIn & (MemReadIn | MemWriteIn)
                     & misaligned(MemSizeIn, ALUResultIn[1:0]);
`endif
        taken_nxt = ValidIn & br_cmp;
        // Non-valid slots carry no side effects; a faulting access must not
        // write memory or the register file.
        ctrl_nxt = '0;
        if (ValidIn) begin
            ctrl_nxt.regwrite = RegWriteIn & ~addr_err_nxt;
            ctrl_nxt.memread  = MemReadIn  & ~addr_err_nxt;
            ctrl_nxt.memwrite = MemWriteIn & ~addr_err_nxt;
            ctrl_nxt.memtoreg = MemToRegIn;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset || Flush) begin
            // Reset and bubble both clear every field.
            ValidOut     <= 1'b0;
            ALUResultOut <= '0;
            StoreDataOut <= '0;
            WriteRegOut  <= '0;
            RegWriteOut  <= 1'b0;
            MemReadOut   <= 1'b0;
            MemWriteOut  <= 1'b0;
            MemToRegOut  <= 1'b0;
            MemSizeOut   <= '0;
            BranchTaken  <= 1'b0;
            BranchTarget <= '0;
`ifdef MISALIGN_CHECK_EN
            AddrErr      <= 1'b0;
`endif
        end else if (!Stall) begin
            ValidOut     <= ValidIn;
            ALUResultOut <= ALUResultIn;
            StoreDataOut <= StoreDataIn;
            WriteRegOut  <= WriteRegIn;
            RegWriteOut  <= ctrl_nxt.regwrite;
            MemReadOut   <= ctrl_nxt.memread;
            MemWriteOut  <= ctrl_nxt.memwrite;
            MemToRegOut  <= ctrl_nxt.memtoreg;
            MemSizeOut   <= MemSizeIn;
            BranchTaken  <= taken_nxt;
            BranchTarget <= BranchTargetIn;
`ifdef MISALIGN_CHECK_EN
            AddrErr      <= addr_err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_ex_mem_register.sv
module tb_ex_mem_register;

    logic        Clk = 1'b0;
    logic        Reset, Stall, Flush, ValidIn, ZeroIn;
    logic [31:0] ALUResultIn, StoreDataIn, BranchTargetIn;
    logic [4:0]  WriteRegIn;
    logic        RegWriteIn, MemReadIn, MemWriteIn, MemToRegIn;
    logic [1:0]  MemSizeIn;
    logic [2:0]  BranchTypeIn;
    logic        ValidOut, RegWriteOut, MemReadOut, MemWriteOut, MemToRegOut, BranchTaken;
    logic [31:0] ALUResultOut, StoreDataOut, BranchTarget;
    logic [4:0]  WriteRegOut;
    logic [1:0]  MemSizeOut;
`ifdef MISALIGN_CHECK_EN
    logic        AddrErr;
`endif

    int errors = 0;
    int checks = 0;

    ex_mem_register dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .ValidIn(ValidIn),
        .ALUResultIn(ALUResultIn), .ZeroIn(ZeroIn), .StoreDataIn(StoreDataIn),
        .WriteRegIn(WriteRegIn), .RegWriteIn(RegWriteIn), .MemReadIn(MemReadIn),
        .MemWriteIn(MemWriteIn), .MemToRegIn(MemToRegIn), .MemSizeIn(MemSizeIn),
        .BranchTypeIn(BranchTypeIn), .BranchTargetIn(BranchTargetIn),
        .ValidOut(ValidOut), .ALUResultOut(ALUResultOut), .StoreDataOut(StoreDataOut),
        .WriteRegOut(WriteRegOut), .RegWriteOut(RegWriteOut), .MemReadOut(MemReadOut),
        .MemWriteOut(MemWriteOut), .MemToRegOut(MemToRegOut), .MemSizeOut(MemSizeOut),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget)
`ifdef MISALIGN_CHECK_EN
        , .AddrErr(AddrErr)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] alu;
        logic [2:0]  bt;
        logic        regw;
        logic        memw;
        logic        exp_taken;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic v, logic [31:0] a, logic [2:0] b,
                                logic rw, logic mw, logic et);
        vec_t x;
        x.name = n; x.valid = v; x.alu = a; x.bt = b; x.regw = rw; x.memw = mw;
        x.exp_taken = et;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        Stall = 0; Flush = 0; ValidIn = 0; ALUResultIn = 0; ZeroIn = 0;
        StoreDataIn = 0; WriteRegIn = 0; RegWriteIn = 0; MemReadIn = 0;
        MemWriteIn = 0; MemToRegIn = 0; MemSizeIn = 0; BranchTypeIn = 0;
        BranchTargetIn = 0;
    endtask

    task automatic load(input logic v, input logic [31:0] a, input logic [2:0] b,
                        input logic rw, input logic mw, input logic [31:0] tgt);
        ValidIn = v; ALUResultIn = a; ZeroIn = (a == 32'd0); BranchTypeIn = b;
        RegWriteIn = rw; MemWriteIn = mw; BranchTargetIn = tgt;
    endtask

    initial begin
        Reset = 1'b0;
        idle();

        // 1. reset with random inputs, then first load
        for (int i = 0; i < 2; i++) begin
            ValidIn = 1; ALUResultIn = $urandom; ZeroIn = 1; StoreDataIn = $urandom;
            WriteRegIn = 5'h1f; RegWriteIn = 1; MemReadIn = 1; MemWriteIn = 1;
            MemToRegIn = 1; MemSizeIn = 2'b10; BranchTypeIn = 3'd1;
            BranchTargetIn = $urandom; Stall = i[0]; Flush = 0;
            step();
        end
        chk("rst_valid", {31'd0, ValidOut}, 0);
        chk("rst_alu", ALUResultOut, 0);
        chk("rst_store", StoreDataOut, 0);
        chk("rst_ctrl", {WriteRegOut, RegWriteOut, MemReadOut, MemWriteOut, MemToRegOut, MemSizeOut}, 0);
        chk("rst_branch", {31'd0, BranchTaken}, 0);
        chk("rst_target", BranchTarget, 0);
        Reset = 1'b1;
        idle();
        ValidIn = 1; ALUResultIn = 32'h1234; StoreDataIn = 32'hCAFE; WriteRegIn = 5'd9;
        MemSizeIn = 2'b01;
        step();
        chk("first_alu", ALUResultOut, 32'h1234);
        chk("first_valid", {31'd0, ValidOut}, 1);
        chk("first_store", StoreDataOut, 32'hCAFE);
        chk("first_wreg", {27'd0, WriteRegOut}, 9);
        chk("first_size", {30'd0, MemSizeOut}, 1);

        // 2. table: branch sweep and ValidIn=0 suppression
        vecs.push_back(mk("bltz_neg1", 1, 32'hFFFF_FFFF, 3'd6, 0, 0, 1));
        vecs.push_back(mk("bltz_zero", 1, 32'h0, 3'd6, 0, 0, 0));
        vecs.push_back(mk("beq_0",  1, 32'd0, 3'd1, 0, 0, 1));
        vecs.push_back(mk("bne_0",  1, 32'd0, 3'd2, 0, 0, 0));
        vecs.push_back(mk("bgez_0", 1, 32'd0, 3'd3, 0, 0, 1));
        vecs.push_back(mk("bgtz_0", 1, 32'd0, 3'd4, 0, 0, 0));
        vecs.push_back(mk("blez_0", 1, 32'd0, 3'd5, 0, 0, 1));
        vecs.push_back(mk("bltz_0", 1, 32'd0, 3'd6, 0, 0, 0));
        vecs.push_back(mk("beq_5",  1, 32'd5, 3'd1, 0, 0, 0));
        vecs.push_back(mk("bne_5",  1, 32'd5, 3'd2, 0, 0, 1));
        vecs.push_back(mk("bgez_5", 1, 32'd5, 3'd3, 0, 0, 1));
        vecs.push_back(mk("bgtz_5", 1, 32'd5, 3'd4, 0, 0, 1));
        vecs.push_back(mk("blez_5", 1, 32'd5, 3'd5, 0, 0, 0));
        vecs.push_back(mk("bltz_5", 1, 32'd5, 3'd6, 0, 0, 0));
        vecs.push_back(mk("beq_m5",  1, 32'hFFFF_FFFB, 3'd1, 0, 0, 0));
        vecs.push_back(mk("bne_m5",  1, 32'hFFFF_FFFB, 3'd2, 0, 0, 1));
        vecs.push_back(mk("bgez_m5", 1, 32'hFFFF_FFFB, 3'd3, 0, 0, 0));
        vecs.push_back(mk("bgtz_m5", 1, 32'hFFFF_FFFB, 3'd4, 0, 0, 0));
        vecs.push_back(mk("blez_m5", 1, 32'hFFFF_FFFB, 3'd5, 0, 0, 1));
        vecs.push_back(mk("bltz_m5", 1, 32'hFFFF_FFFB, 3'd6, 0, 0, 1));
        vecs.push_back(mk("none0_0", 1, 32'd0, 3'd0, 1, 0, 0));
        vecs.push_back(mk("none7_0", 1, 32'd0, 3'd7, 1, 0, 0));
        vecs.push_back(mk("add_res", 1, 32'd42, 3'd0, 1, 0, 0));
        vecs.push_back(mk("sw_aligned", 1, 32'h1000, 3'd0, 0, 1, 0));
        vecs.push_back(mk("invalid_beq", 0, 32'd0, 3'd1, 1, 1, 0));
        vecs.push_back(mk("invalid_bne", 0, 32'd5, 3'd2, 1, 0, 0));

        idle();
        foreach (vecs[i]) begin
            load(vecs[i].valid, vecs[i].alu, vecs[i].bt, vecs[i].regw, vecs[i].memw,
                 32'h400 + 32'(i) * 4);
            MemToRegIn = 1;
            step();
            chk({vecs[i].name, "_taken"}, {31'd0, BranchTaken}, {31'd0, vecs[i].exp_taken});
            chk({vecs[i].name, "_alu"}, ALUResultOut, vecs[i].alu);
            chk({vecs[i].name, "_valid"}, {31'd0, ValidOut}, {31'd0, vecs[i].valid});
            chk({vecs[i].name, "_regw"}, {31'd0, RegWriteOut}, {31'd0, vecs[i].valid & vecs[i].regw});
            chk({vecs[i].name, "_memw"}, {31'd0, MemWriteOut}, {31'd0, vecs[i].valid & vecs[i].memw});
            chk({vecs[i].name, "_m2r"}, {31'd0, MemToRegOut}, {31'd0, vecs[i].valid});
            chk({vecs[i].name, "_tgt"}, BranchTarget, 32'h400 + 32'(i) * 4);
        end

        // 3. stall holds everything, including a taken branch
        idle();
        load(1, 32'd7, 3'd5, 1, 0, 32'h800);   // blez on 7: not taken
        step();
        load(1, 32'd0, 3'd1, 1, 0, 32'h900);   // beq taken
        step();
        chk("pre_stall_taken", {31'd0, BranchTaken}, 1);
        load(1, 32'd7, 3'd0, 1, 0, 32'h0);
        step();
        chk("addi7_alu", ALUResultOut, 7);
        load(1, 32'd99, 3'd2, 0, 1, 32'hA00);
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_alu", ALUResultOut, 7);
            chk("stall_regw", {31'd0, RegWriteOut}, 1);
            chk("stall_memw", {31'd0, MemWriteOut}, 0);
            chk("stall_taken", {31'd0, BranchTaken}, 0);
        end
        Stall = 0;
        step();
        chk("unstall_alu", ALUResultOut, 99);
        chk("unstall_taken", {31'd0, BranchTaken}, 1);
        chk("unstall_tgt", BranchTarget, 32'hA00);
        // taken branch held through stall
        load(1, 32'd7, 3'd0, 1, 0, 32'h0);
        Stall = 1;
        step();
        chk("stall_hold_taken", {31'd0, BranchTaken}, 1);
        chk("stall_hold_tgt", BranchTarget, 32'hA00);

        // 4. stall + flush on a taken beq -> bubble
        load(1, 32'd0, 3'd1, 1, 1, 32'hB00);
        Stall = 1; Flush = 1;
        step();
        chk("flush_valid", {31'd0, ValidOut}, 0);
        chk("flush_taken", {31'd0, BranchTaken}, 0);
        chk("flush_regw", {31'd0, RegWriteOut}, 0);
        chk("flush_memw", {31'd0, MemWriteOut}, 0);
        chk("flush_alu", ALUResultOut, 0);

        // reset during stall wins, then normal priority resumes
        Flush = 0; Stall = 0;
        load(1, 32'd55, 3'd0, 1, 0, 32'h0);
        step();
        Stall = 1; Reset = 0;
        step();
        chk("rst_in_stall_alu", ALUResultOut, 0);
        chk("rst_in_stall_valid", {31'd0, ValidOut}, 0);
        Reset = 1; Stall = 0;
        load(1, 32'd66, 3'd0, 1, 0, 32'h0);
        step();
        chk("post_rst_alu", ALUResultOut, 66);

`ifdef MISALIGN_CHECK_EN
        // 6. alignment check
        idle();
        ValidIn = 1; ALUResultIn = 32'h1002; MemWriteIn = 1; MemSizeIn = 2'b00;
        step();
        chk("sw_mis_err", {31'd0, AddrErr}, 1);
        chk("sw_mis_memw", {31'd0, MemWriteOut}, 0);
        MemSizeIn = 2'b01;
        step();
        chk("sh_ok_err", {31'd0, AddrErr}, 0);
        chk("sh_ok_memw", {31'd0, MemWriteOut}, 1);
        MemWriteIn = 0; MemReadIn = 1; RegWriteIn = 1; ALUResultIn = 32'h1001;
        step();
        chk("lh_mis_err", {31'd0, AddrErr}, 1);
        chk("lh_mis_ctl", {30'd0, MemReadOut, RegWriteOut}, 0);
        MemSizeIn = 2'b10;
        step();
        chk("lb_ok_err", {31'd0, AddrErr}, 0);
        chk("lb_ok_ctl", {30'd0, MemReadOut, RegWriteOut}, 3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
